// File: rtl/ram_port_arbiter_if.sv
// Word-transaction port between one master and the RAM data-port arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
);
  logic                req;
  logic                we;
  logic [3:0]          be;
  logic [ADDR_WIDTH:0] addr;
  logic [DATA_WIDTH:0] wdata;
  logic                gnt;
  logic                done;
  logic [DATA_WIDTH:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter and sequencer for the shared RAM data port (IDLE -> ACCESS -> RESP).
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  ram_port_arbiter_if.slave     m0,
  ram_port_arbiter_if.slave     m1,
  output logic                  ram_read_req,
  output logic [ADDR_WIDTH:0]   ram_read_addr,
  input  logic [DATA_WIDTH:0]   ram_read_data,
  output logic                  ram_write_enable,
  output logic [3:0]            ram_byte_enable,
  output logic [ADDR_WIDTH:0]   ram_write_addr,
  output logic [DATA_WIDTH:0]   ram_write_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                any_req_s;
  logic                arb_s;
  logic                capture_s;
  logic                win_s;
  logic                win_we_s;
  logic [3:0]          win_be_s;
  logic [ADDR_WIDTH:0] win_addr_s;
  logic [DATA_WIDTH:0] win_wdata_s;

  logic                owner_r;
  logic [ADDR_WIDTH:0] addr_r;
  logic [DATA_WIDTH:0] wdata_r;
  logic [DATA_WIDTH:0] rdata0_r;
  logic [DATA_WIDTH:0] rdata1_r;
  logic [1:0]          gnt_r;
  logic [1:0]          done_r;
  logic                rd_r;
  logic                wr_r;
  logic [3:0]          be_r;

  logic [1:0]          gnt_nxt_s;
  logic [1:0]          done_nxt_s;
  logic                rd_nxt_s;
  logic                wr_nxt_s;
  logic [3:0]          be_nxt_s;

  assign any_req_s = m0.req | m1.req;
  assign arb_s     = (state_r == IDLE) || (state_r == RESP);
  assign capture_s = arb_s && any_req_s;

`ifdef RAM_ARB_RR_EN
  logic last_r;

  // Last granted master; starts at m1 so m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (clk_en && capture_s) begin
      last_r <= win_s;
    end
  end

  // Round-robin winner: on contention the master not granted last wins.
  always_comb begin
    if (m0.req && m1.req) begin
      win_s = ~last_r;
    end else begin
      win_s = m1.req;
    end
  end
`else
  // Fixed-priority winner: m0 whenever it requests.
  always_comb begin
    if (m0.req) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`endif

  // Select the winning master's request fields.
  always_comb begin
    if (win_s) begin
      win_we_s    = m1.we;
      win_be_s    = m1.be;
      win_addr_s  = m1.addr;
      win_wdata_s = m1.wdata;
    end else begin
      win_we_s    = m0.we;
      win_be_s    = m0.be;
      win_addr_s  = m0.addr;
      win_wdata_s = m0.wdata;
    end
  end

  // State register; a low clk_en freezes the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (clk_en) begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, RESP: begin
        if (any_req_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS:  next_state_s = RESP;
      default: next_state_s = IDLE;
    endcase
  end

  // Output values for the coming state, registered below.
  always_comb begin
    gnt_nxt_s  = 2'b00;
    done_nxt_s = 2'b00;
    rd_nxt_s   = 1'b0;
    wr_nxt_s   = 1'b0;
    be_nxt_s   = 4'b0000;
    if (next_state_s == ACCESS) begin
      gnt_nxt_s = win_s ? 2'b10 : 2'b01;
      rd_nxt_s  = ~win_we_s;
      wr_nxt_s  = win_we_s;
      be_nxt_s  = win_we_s ? win_be_s : 4'b0000;
    end else if (next_state_s == RESP) begin
      done_nxt_s = owner_r ? 2'b10 : 2'b01;
    end else begin
      done_nxt_s = 2'b00;
    end
  end

  // Output registers, request latch and per-master read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r    <= 2'b00;
      done_r   <= 2'b00;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      be_r     <= 4'b0000;
      owner_r  <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata0_r <= '0;
      rdata1_r <= '0;
    end else if (clk_en) begin
      gnt_r  <= gnt_nxt_s;
      done_r <= done_nxt_s;
      rd_r   <= rd_nxt_s;
      wr_r   <= wr_nxt_s;
      be_r   <= be_nxt_s;
      if (capture_s) begin
        owner_r <= win_s;
        addr_r  <= win_addr_s;
        wdata_r <= win_wdata_s;
      end
      if ((state_r == ACCESS) && rd_r) begin
        if (owner_r) begin
          rdata1_r <= ram_read_data;
        end else begin
          rdata0_r <= ram_read_data;
        end
      end
    end
  end

  assign m0.gnt   = gnt_r[0];
  assign m1.gnt   = gnt_r[1];
  assign m0.done  = done_r[0];
  assign m1.done  = done_r[1];
  assign m0.rdata = rdata0_r;
  assign m1.rdata = rdata1_r;

  // A reset arriving mid-ACCESS must stop the write from landing that same edge.
  assign ram_write_enable = wr_r & ~rst;
  assign ram_read_req     = rd_r;
  assign ram_byte_enable  = be_r;
  assign ram_read_addr    = addr_r;
  assign ram_write_addr   = addr_r;
  assign ram_write_data   = wdata_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a 16-word RAM model and a slot-level reference model.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        ram_read_req;
  logic [31:0] ram_read_addr;
  logic [31:0] ram_read_data;
  logic        ram_write_enable;
  logic [3:0]  ram_byte_enable;
  logic [31:0] ram_write_addr;
  logic [31:0] ram_write_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if m0 ();
  ram_port_arbiter_if m1 ();

  ram_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .m0               (m0),
    .m1               (m1),
    .ram_read_req     (ram_read_req),
    .ram_read_addr    (ram_read_addr),
    .ram_read_data    (ram_read_data),
    .ram_write_enable (ram_write_enable),
    .ram_byte_enable  (ram_byte_enable),
    .ram_write_addr   (ram_write_addr),
    .ram_write_data   (ram_write_data)
  );

  // RAM model shares the global clock enable; bd_* is a backdoor preload path
  logic [31:0] mem [16];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr = 4'd0;
  logic [31:0] bd_data = 32'd0;
  int          wr_count = 0;

  assign ram_read_data = mem[ram_read_addr[3:0]];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (clk_en && ram_write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_byte_enable[i]) mem[ram_write_addr[3:0]][8*i +: 8] <= ram_write_data[8*i +: 8];
      end
      wr_count <= wr_count + 1;
    end
  end

  logic        t_req [2];
  logic        t_we [2];
  logic [3:0]  t_be [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];
  logic [31:0] ref_mem [16];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic drive_masters();
    m0.req = t_req[0]; m0.we = t_we[0]; m0.be = t_be[0]; m0.addr = t_addr[0]; m0.wdata = t_wdata[0];
    m1.req = t_req[1]; m1.we = t_we[1]; m1.be = t_be[1]; m1.addr = t_addr[1]; m1.wdata = t_wdata[1];
  endtask

  task automatic idle_masters();
    for (int k = 0; k < 2; k++) begin
      t_req[k] = 1'b0; t_we[k] = 1'b0; t_be[k] = 4'h0; t_addr[k] = 32'd0; t_wdata[k] = 32'd0;
    end
    drive_masters();
  endtask

  task automatic bd_write(input logic [3:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    idle_masters();
    rst = 1'b1; clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0.gnt, m1.gnt, m0.done, m1.done, ram_read_req, ram_write_enable, ram_byte_enable} !== 10'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {m0.gnt, m1.gnt, m0.done, m1.done, ram_read_req, ram_write_enable, ram_byte_enable}); end
    checks++;
    if ({ram_read_addr, ram_write_addr, ram_write_data} !== 96'b0)
      begin failures++; $display("FAIL reset_bus got=%h exp=0", {ram_read_addr, ram_write_addr, ram_write_data}); end
    checks++;
    if ({m0.rdata, m1.rdata} !== 64'b0)
      begin failures++; $display("FAIL reset_rdata got=%h exp=0", {m0.rdata, m1.rdata}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0.gnt, m1.gnt} !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b exp=00", {m0.gnt, m1.gnt}); end
  endtask

  task automatic test_read_basic();
    bd_write(4'd5, 32'hDEADBEEF);
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'd5;
    @(negedge clk);
    checks++;
    if ({m0.gnt, m1.gnt, ram_read_req, ram_write_enable, m0.done} !== 5'b10100)
      begin failures++; $display("FAIL rd_access got=%b exp=10100", {m0.gnt, m1.gnt, ram_read_req, ram_write_enable, m0.done}); end
    checks++;
    if (ram_read_addr !== 32'd5) begin failures++; $display("FAIL rd_addr got=%h exp=5", ram_read_addr); end
    m0.req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0.done, m1.done, m0.gnt, ram_read_req} !== 4'b1000)
      begin failures++; $display("FAIL rd_resp got=%b exp=1000", {m0.done, m1.done, m0.gnt, ram_read_req}); end
    checks++;
    if (m0.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", m0.rdata); end
    @(negedge clk);
    checks++;
    if ({m0.done, m0.rdata} !== {1'b0, 32'hDEADBEEF})
      begin failures++; $display("FAIL rd_hold got=%b/%h exp=0/deadbeef", m0.done, m0.rdata); end
  endtask

  task automatic test_write_be();
    bd_write(4'd3, 32'hAAAAAAAA);
    m1.req = 1'b1; m1.we = 1'b1; m1.be = 4'b0101; m1.addr = 32'd3; m1.wdata = 32'h11223344;
    @(negedge clk);
    checks++;
    if ({m1.gnt, m0.gnt, ram_write_enable, ram_read_req} !== 4'b1010)
      begin failures++; $display("FAIL wr_access got=%b exp=1010", {m1.gnt, m0.gnt, ram_write_enable, ram_read_req}); end
    checks++;
    if ({ram_byte_enable, ram_write_addr, ram_write_data} !== {4'b0101, 32'd3, 32'h11223344})
      begin failures++; $display("FAIL wr_bus got=%h exp=%h", {ram_byte_enable, ram_write_addr, ram_write_data}, {4'b0101, 32'd3, 32'h11223344}); end
    m1.req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1.done, ram_write_enable, ram_byte_enable} !== 6'b100000)
      begin failures++; $display("FAIL wr_resp got=%b exp=100000", {m1.done, ram_write_enable, ram_byte_enable}); end
    checks++;
    if (mem[3] !== 32'hAA22AA44) begin failures++; $display("FAIL wr_merge got=%h exp=aa22aa44", mem[3]); end
    checks++;
    if (m1.rdata !== 32'd0) begin failures++; $display("FAIL wr_rdata_kept got=%h exp=0", m1.rdata); end
    m1.req = 1'b1; m1.be = 4'b0000; m1.wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({m1.gnt, ram_byte_enable} !== 5'b10000)
      begin failures++; $display("FAIL be0_access got=%b exp=10000", {m1.gnt, ram_byte_enable}); end
    m1.req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1.done, mem[3]} !== {1'b1, 32'hAA22AA44})
      begin failures++; $display("FAIL be0_resp got=%b/%h exp=1/aa22aa44", m1.done, mem[3]); end
  endtask

  task automatic test_contention();
    int gm [8];
    int gc [8];
    int n;
    int exp_m;
    do_reset();
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'd1;
    m1.req = 1'b1; m1.we = 1'b0; m1.addr = 32'd2;
    n = 0;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      @(negedge clk);
      checks++;
      if (m0.gnt && m1.gnt) begin failures++; $display("FAIL cont_double_gnt cycle=%0d got=11 exp=one-hot", c); end
      if (m0.gnt || m1.gnt) begin gm[n] = m1.gnt ? 1 : 0; gc[n] = c; n++; end
    end
    m0.req = 1'b0; m1.req = 1'b0;
    checks++;
    if (n !== 8) begin failures++; $display("FAIL cont_count got=%0d exp=8", n); end
    for (int k = 0; k < n; k++) begin
`ifdef RAM_ARB_RR_EN
      exp_m = k % 2;
`else
      exp_m = 0;
`endif
      checks++;
      if (gm[k] !== exp_m) begin failures++; $display("FAIL cont_owner idx=%0d got=m%0d exp=m%0d", k, gm[k], exp_m); end
      checks++;
      if (gc[k] !== ((k == 0) ? 1 : gc[k-1] + 2))
        begin failures++; $display("FAIL cont_spacing idx=%0d got=%0d exp=%0d", k, gc[k], (k == 0) ? 1 : gc[k-1] + 2); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clk_en();
    int cnt0;
    bd_write(4'd9, 32'h0);
    cnt0 = wr_count;
    m0.req = 1'b1; m0.we = 1'b1; m0.be = 4'hF; m0.addr = 32'd9; m0.wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (m0.gnt !== 1'b1) begin failures++; $display("FAIL ce_gnt got=%b exp=1", m0.gnt); end
    m0.req = 1'b0; clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({m0.gnt, m0.done, ram_write_enable} !== 3'b101)
        begin failures++; $display("FAIL ce_hold cyc=%0d got=%b exp=101", c, {m0.gnt, m0.done, ram_write_enable}); end
    end
    clk_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0.gnt, m0.done} !== 2'b01) begin failures++; $display("FAIL ce_done got=%b exp=01", {m0.gnt, m0.done}); end
    checks++;
    if ((wr_count - cnt0) !== 1) begin failures++; $display("FAIL ce_write_count got=%0d exp=1", wr_count - cnt0); end
    checks++;
    if (mem[9] !== 32'hCAFEF00D) begin failures++; $display("FAIL ce_mem got=%h exp=cafef00d", mem[9]); end
    @(negedge clk);
    checks++;
    if (m0.done !== 1'b0) begin failures++; $display("FAIL ce_done_end got=%b exp=0", m0.done); end
  endtask

  task automatic test_reset_access();
    int cnt0;
    bd_write(4'd7, 32'h5A5A5A5A);
    cnt0 = wr_count;
    m1.req = 1'b1; m1.we = 1'b1; m1.be = 4'hF; m1.addr = 32'd7; m1.wdata = 32'h0;
    @(negedge clk);
    checks++;
    if (m1.gnt !== 1'b1) begin failures++; $display("FAIL rsta_gnt got=%b exp=1", m1.gnt); end
    rst = 1'b1; m1.req = 1'b0;
    #1;
    checks++;
    if (ram_write_enable !== 1'b0) begin failures++; $display("FAIL rsta_wen got=%b exp=0", ram_write_enable); end
    @(negedge clk);
    checks++;
    if ({m0.gnt, m1.gnt, m0.done, m1.done, ram_read_req, ram_write_enable, ram_byte_enable,
         ram_read_addr, ram_write_addr, ram_write_data} !== 106'b0)
      begin failures++; $display("FAIL rsta_outputs got=%h exp=0", {m1.done, ram_byte_enable, ram_write_addr, ram_write_data}); end
    checks++;
    if ({mem[7], wr_count - cnt0} !== {32'h5A5A5A5A, 32'd0})
      begin failures++; $display("FAIL rsta_mem got=%h/%0d exp=5a5a5a5a/0", mem[7], wr_count - cnt0); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1.done, m1.gnt} !== 2'b00) begin failures++; $display("FAIL rsta_nodone got=%b exp=00", {m1.done, m1.gnt}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d2, d4;
    logic [1:0]  exp_gd [4];
    d2 = $urandom; d4 = $urandom;
    bd_write(4'd2, d2);
    bd_write(4'd4, d4);
    exp_gd[0] = 2'b10; exp_gd[1] = 2'b01; exp_gd[2] = 2'b10; exp_gd[3] = 2'b01;
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'd2;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({m0.gnt, m0.done} !== exp_gd[c-1])
        begin failures++; $display("FAIL b2b_seq cycle=%0d got=%b exp=%b", c, {m0.gnt, m0.done}, exp_gd[c-1]); end
      if (c == 1) m0.addr = 32'd4;
      if (c == 3) m0.req = 1'b0;
      if (c == 2 || c == 4) begin
        checks++;
        if (m0.rdata !== ((c == 2) ? d2 : d4))
          begin failures++; $display("FAIL b2b_data cycle=%0d got=%h exp=%h", c, m0.rdata, (c == 2) ? d2 : d4); end
      end
    end
  endtask

  // Random traffic against a slot model: the port is free two cycles after each grant.
  task automatic test_random();
    int          free_at;
    logic [1:0]  preq, exp_gnt, exp_done, done_sched;
    logic        w, pend_rd, pend_m, exp_wen, exp_ren;
    logic [31:0] pend_data;
    logic [31:0] exp_rd [2];
    logic [3:0]  a;
`ifdef RAM_ARB_RR_EN
    logic        last;
    last = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bd_write(i[3:0], ref_mem[i]);
    end
    do_reset();
    free_at = 1; done_sched = 2'b00; pend_rd = 1'b0; pend_m = 1'b0; pend_data = 32'd0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      preq = {t_req[1], t_req[0]};
      @(negedge clk);
      exp_done = done_sched; done_sched = 2'b00;
      if (pend_rd) begin exp_rd[pend_m] = pend_data; pend_rd = 1'b0; end
      exp_gnt = 2'b00; exp_wen = 1'b0; exp_ren = 1'b0;
      if (cyc >= free_at && preq != 2'b00) begin
`ifdef RAM_ARB_RR_EN
        w = (preq == 2'b11) ? ~last : preq[1];
        last = w;
`else
        w = ~preq[0];
`endif
        free_at = cyc + 2;
        exp_gnt[w] = 1'b1; done_sched[w] = 1'b1;
        a = t_addr[w][3:0];
        if (t_we[w]) begin
          exp_wen = 1'b1;
          ref_mem[a] = merge(ref_mem[a], t_wdata[w], t_be[w]);
        end else begin
          exp_ren = 1'b1; pend_rd = 1'b1; pend_m = w; pend_data = ref_mem[a];
        end
      end
      checks++;
      if ({m1.gnt, m0.gnt} !== exp_gnt) begin failures++; $display("FAIL rnd_gnt cycle=%0d got=%b exp=%b", cyc, {m1.gnt, m0.gnt}, exp_gnt); end
      checks++;
      if ({m1.done, m0.done} !== exp_done) begin failures++; $display("FAIL rnd_done cycle=%0d got=%b exp=%b", cyc, {m1.done, m0.done}, exp_done); end
      checks++;
      if ({ram_write_enable, ram_read_req} !== {exp_wen, exp_ren})
        begin failures++; $display("FAIL rnd_ram_en cycle=%0d got=%b exp=%b", cyc, {ram_write_enable, ram_read_req}, {exp_wen, exp_ren}); end
      checks++;
      if ({m1.rdata, m0.rdata} !== {exp_rd[1], exp_rd[0]})
        begin failures++; $display("FAIL rnd_rdata cycle=%0d got=%h exp=%h", cyc, {m1.rdata, m0.rdata}, {exp_rd[1], exp_rd[0]}); end
      for (int k = 0; k < 2; k++) begin
        if ((exp_gnt[k] && ($urandom_range(1, 0) == 1)) || (!t_req[k] && ($urandom_range(4, 0) < 2))) begin
          t_req[k] = 1'b1; t_we[k] = $urandom_range(1, 0) == 1; t_be[k] = 4'($urandom);
          t_addr[k] = 32'($urandom_range(15, 0)); t_wdata[k] = $urandom;
        end else if (exp_gnt[k]) begin
          t_req[k] = 1'b0;
        end
      end
      drive_masters();
    end
    idle_masters();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    idle_masters();
    test_reset();
    test_read_basic();
    test_write_be();
    test_contention();
    test_clk_en();
    test_reset_access();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
